// File: rtl/fc_pkg.sv
// rtl/fc_pkg.sv - shared state type, index-width helper and saturation for fc_layer_engine
package fc_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        FINAL,
        DRAIN
    } fc_state_t;

    localparam int SAT_W = 64;

    // Index width that stays legal (>=1 bit) for single-entry ranges
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic logic signed [SAT_W-1:0] sat_signed(
        input logic signed [SAT_W-1:0] value,
        input int                      out_width
    );
        logic signed [SAT_W-1:0] hi;
        logic signed [SAT_W-1:0] lo;
        hi = (64'sd1 <<< (out_width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (value > hi) begin
            return hi;
        end
        if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/fc_mac_lane.sv
// rtl/fc_mac_lane.sv - one MAC lane: overwrite on load, accumulate on acc_en
module fc_mac_lane #(
    parameter int DW   = 10,
    parameter int WW   = 9,
    parameter int ACCW = 25
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   load,
    input  logic                   acc_en,
    input  logic signed [DW-1:0]   in_data,
    input  logic signed [WW-1:0]   weight,
    output logic signed [ACCW-1:0] acc
);

    logic signed [DW+WW-1:0] w_prod;
    logic signed [ACCW-1:0]  w_prod_ext;
    logic signed [ACCW-1:0]  r_acc;

    assign w_prod     = in_data * weight;
    assign w_prod_ext = ACCW'(w_prod);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= '0;
        end else if (load) begin
            r_acc <= w_prod_ext;
        end else if (acc_en) begin
            r_acc <= r_acc + w_prod_ext;
        end
    end

    assign acc = r_acc;

endmodule

// File: rtl/fc_layer_engine.sv
// rtl/fc_layer_engine.sv - parametrised FC layer: MAC lanes, bias/shift/saturate, streamed drain
// Optional macro FC_RELU_EN clamps negative saturated results to zero.
module fc_layer_engine
    import fc_pkg::*;
#(
    parameter int N_IN  = 64,
    parameter int N_OUT = 16,
    parameter int DW    = 10,
    parameter int WW    = 9,
    parameter int BW    = 11,
    parameter int ACCW  = 25,
    parameter int OW    = 16,
    parameter int SHIFT = 0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       in_valid,
    input  logic [DW-1:0]              in_data,
    output logic                       in_ready,
    output logic [idx_w(N_IN)-1:0]     w_addr,
    input  logic [N_OUT*WW-1:0]        weight,
    input  logic [N_OUT*BW-1:0]        bias,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OW-1:0]              out_data,
    output logic [idx_w(N_OUT)-1:0]    out_idx,
    output logic                       layer_done
);

    localparam int IN_W  = idx_w(N_IN);
    localparam int OUT_W = idx_w(N_OUT);

    fc_state_t              r_state;
    fc_state_t              w_next_state;
    logic [IN_W-1:0]        r_in_cnt;
    logic [OUT_W-1:0]       r_out_idx;
    logic                   r_done;
    logic signed [OW-1:0]   r_obuf [N_OUT];
    logic signed [OW-1:0]   w_res  [N_OUT];
    logic signed [ACCW-1:0] w_acc  [N_OUT];
    logic                   w_in_fire;
    logic                   w_last_in;
    logic                   w_out_fire;
    logic                   w_last_out;

    // in_ready is gated by rst_n so it reads 0 for the whole reset window
    assign in_ready   = rst_n && ((r_state == IDLE) || (r_state == ACCUM));
    assign w_in_fire  = in_valid && in_ready;
    assign w_last_in  = w_in_fire && (r_in_cnt == IN_W'(N_IN - 1));
    assign out_valid  = (r_state == DRAIN);
    assign w_out_fire = out_valid && out_ready;
    assign w_last_out = w_out_fire && (r_out_idx == OUT_W'(N_OUT - 1));

    assign w_addr     = r_in_cnt;
    assign out_idx    = r_out_idx;
    assign out_data   = out_valid ? r_obuf[r_out_idx] : '0;
    assign layer_done = r_done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_in_fire) w_next_state = w_last_in ? FINAL : ACCUM;
            ACCUM:   if (w_last_in) w_next_state = FINAL;
            FINAL:   w_next_state = DRAIN;
            DRAIN:   if (w_last_out) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_cnt  <= '0;
            r_out_idx <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_last_out;
            if (w_in_fire) begin
                r_in_cnt <= w_last_in ? '0 : r_in_cnt + IN_W'(1);
            end
            if (w_last_out) begin
                r_out_idx <= '0;
            end else if (w_out_fire) begin
                r_out_idx <= r_out_idx + OUT_W'(1);
            end
        end
    end

    genvar k;
    generate
        for (k = 0; k < N_OUT; k++) begin : g_lane
            logic signed [ACCW:0]   w_sum;
            logic signed [ACCW:0]   w_shifted;
            logic signed [OW-1:0]   w_clip;

            fc_mac_lane #(
                .DW   (DW),
                .WW   (WW),
                .ACCW (ACCW)
            ) u_lane (
                .clk     (clk),
                .rst_n   (rst_n),
                .load    (w_in_fire && (r_state == IDLE)),
                .acc_en  (w_in_fire && (r_state == ACCUM)),
                .in_data (in_data),
                .weight  (weight[k*WW +: WW]),
                .acc     (w_acc[k])
            );

            // One guard bit keeps acc + bias exact before the shift
            assign w_sum     = (ACCW+1)'(w_acc[k]) + (ACCW+1)'($signed(bias[k*BW +: BW]));
            assign w_shifted = w_sum >>> SHIFT;
            assign w_clip    = OW'(sat_signed(SAT_W'(w_shifted), OW));
`ifdef FC_RELU_EN
            assign w_res[k]  = w_clip[OW-1] ? '0 : w_clip;
`else
            assign w_res[k]  = w_clip;
`endif
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_OUT; i++) begin
                r_obuf[i] <= '0;
            end
        end else if (r_state == FINAL) begin
            for (int i = 0; i < N_OUT; i++) begin
                r_obuf[i] <= w_res[i];
            end
        end
    end

endmodule

// File: tb/tb_fc_layer_engine.sv
// tb/tb_fc_layer_engine.sv - scoreboard bench for fc_layer_engine (N_IN=4, N_OUT=2), FC_RELU_EN aware
`timescale 1ns/1ps
module tb_fc_layer_engine;

    localparam int N_IN  = 4;
    localparam int N_OUT = 2;
    localparam int DW    = 10;
    localparam int WW    = 9;
    localparam int BW    = 11;
    localparam int ACCW  = 25;
    localparam int OW    = 16;
    localparam int SHIFT = 0;

    typedef logic signed [63:0] val_t;
    typedef struct {
        val_t data;
        val_t idx;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 in_valid = 1'b0;
    logic [DW-1:0]        in_data = '0;
    logic                 in_ready;
    logic [1:0]           w_addr;
    logic [N_OUT*WW-1:0]  weight;
    logic [N_OUT*BW-1:0]  bias;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [OW-1:0]        out_data;
    logic [0:0]           out_idx;
    logic                 layer_done;

    int   wmem [N_IN][N_OUT];
    int   bias_v [N_OUT];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        weight = '0;
        bias   = '0;
        for (int k = 0; k < N_OUT; k++) begin
            weight[k*WW +: WW] = WW'(wmem[w_addr][k]);
            bias[k*BW +: BW]   = BW'(bias_v[k]);
        end
    end

    fc_layer_engine #(
        .N_IN(N_IN), .N_OUT(N_OUT), .DW(DW), .WW(WW), .BW(BW),
        .ACCW(ACCW), .OW(OW), .SHIFT(SHIFT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .w_addr     (w_addr),
        .weight     (weight),
        .bias       (bias),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .layer_done (layer_done)
    );

    task automatic check(input string tag, input val_t obs, input val_t expd);
        checks++;
        assert (obs === expd) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expd);
        end
    endtask

    function automatic val_t model(input int a[N_IN], input int k);
        val_t s;
        val_t hi;
        s  = 0;
        hi = (val_t'(1) <<< (OW - 1)) - 1;
        for (int i = 0; i < N_IN; i++) begin
            s += val_t'(a[i]) * val_t'(wmem[i][k]);
        end
        s += val_t'(bias_v[k]);
        s = s >>> SHIFT;
        if (s > hi) s = hi;
        else if (s < -hi - 1) s = -hi - 1;
`ifdef FC_RELU_EN
        if (s < 0) s = 0;
`endif
        return s;
    endfunction

    task automatic set_weights(input int w0, input int w1, input int b0, input int b1);
        for (int i = 0; i < N_IN; i++) begin
            wmem[i][0] = w0;
            wmem[i][1] = w1;
        end
        bias_v[0] = b0;
        bias_v[1] = b1;
    endtask

    task automatic send_vector(input int a[N_IN], input int gap);
        for (int k = 0; k < N_OUT; k++) begin
            sb.push_back('{data: model(a, k), idx: val_t'(k)});
        end
        for (int i = 0; i < N_IN; i++) begin
            int n;
            n = 0;
            in_valid = 1'b1;
            in_data  = DW'(a[i]);
            while (!in_ready && n < 100) begin
                @(negedge clk);
                n++;
            end
            check("in_ready_accept", val_t'(in_ready), 1);
            check("w_addr", val_t'(w_addr), val_t'(i));
            @(negedge clk);
            in_valid = 1'b0;
            if (i < N_IN - 1) repeat (gap) @(negedge clk);
        end
    endtask

    // Entered on the negedge right after the last input was accepted
    task automatic drain(input int stall_idx, input int stall_len, input bit next_pending);
        int   beats;
        int   stalled;
        int   guard;
        val_t held_data;
        val_t held_idx;
        exp_t e;
        beats = 0; stalled = 0; guard = 0; held_data = 0; held_idx = 0;
        check("sb_depth", val_t'(sb.size()), N_OUT);
        check("final_out_valid", val_t'(out_valid), 0);
        check("final_in_ready", val_t'(in_ready), 0);
        @(negedge clk);
        check("drain_out_valid", val_t'(out_valid), 1);
        while (beats < N_OUT && guard < 100) begin
            guard++;
            check("drain_in_ready", val_t'(in_ready), 0);
            check("drain_done_low", val_t'(layer_done), 0);
            if (beats == stall_idx && stalled < stall_len) begin
                out_ready = 1'b0;
                if (stalled == 0) begin
                    held_data = val_t'($signed(out_data));
                    held_idx  = val_t'(out_idx);
                end else begin
                    check("hold_data", val_t'($signed(out_data)), held_data);
                    check("hold_idx", val_t'(out_idx), held_idx);
                end
                stalled++;
            end else begin
                out_ready = 1'b1;
                if (out_valid && sb.size() > 0) begin
                    e = sb.pop_front();
                    check("out_data", val_t'($signed(out_data)), e.data);
                    check("out_idx", val_t'(out_idx), e.idx);
                    beats++;
                end
            end
            @(negedge clk);
        end
        out_ready = 1'b0;
        check("beats", val_t'(beats), N_OUT);
        check("layer_done_pulse", val_t'(layer_done), 1);
        check("post_out_valid", val_t'(out_valid), 0);
        if (!next_pending) begin
            @(negedge clk);
            check("layer_done_width", val_t'(layer_done), 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1);
    end

    initial begin
        int   a[N_IN];
        int   b[N_IN];
        exp_t e;

        set_weights(2, -3, 5, 0);
        @(negedge clk);
        check("rst_in_ready", val_t'(in_ready), 0);
        check("rst_out_valid", val_t'(out_valid), 0);
        check("rst_out_data", val_t'(out_data), 0);
        check("rst_out_idx", val_t'(out_idx), 0);
        check("rst_layer_done", val_t'(layer_done), 0);
        check("rst_w_addr", val_t'(w_addr), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_in_ready", val_t'(in_ready), 1);

        // Basic vector: 13 / -12 (0 with ReLU)
        a = '{1, 1, 1, 1};
        send_vector(a, 0);
        drain(N_OUT, 0, 1'b0);

        // Saturation in both directions
        set_weights(255, -256, 0, 0);
        a = '{511, 511, 511, 511};
        send_vector(a, 0);
        drain(N_OUT, 0, 1'b0);

        // Random vector drained under backpressure
        for (int i = 0; i < N_IN; i++) begin
            a[i]       = int'($urandom_range(1023)) - 512;
            b[i]       = int'($urandom_range(1023)) - 512;
            wmem[i][0] = int'($urandom_range(511)) - 256;
            wmem[i][1] = int'($urandom_range(511)) - 256;
        end
        bias_v[0] = int'($urandom_range(2047)) - 1024;
        bias_v[1] = int'($urandom_range(2047)) - 1024;
        send_vector(a, 0);
        drain(1, 3, 1'b0);

        // Same vector with input gaps, stall on the first output
        send_vector(a, 2);
        drain(0, 2, 1'b0);

        // Second vector offered during drain must stall, then start fresh
        send_vector(a, 1);
        in_valid = 1'b1;
        in_data  = DW'(b[0]);
        drain(N_OUT, 0, 1'b1);
        send_vector(b, 0);
        drain(N_OUT, 0, 1'b0);

        // Reset while out_idx==1
        set_weights(2, -3, 5, 0);
        a = '{1, 1, 1, 1};
        send_vector(a, 0);
        @(negedge clk);
        check("mid_out_valid", val_t'(out_valid), 1);
        out_ready = 1'b1;
        e = sb.pop_front();
        check("mid_out_data", val_t'($signed(out_data)), e.data);
        @(negedge clk);
        out_ready = 1'b0;
        check("mid_out_idx", val_t'(out_idx), 1);
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", val_t'(out_valid), 0);
        check("abort_out_idx", val_t'(out_idx), 0);
        check("abort_out_data", val_t'(out_data), 0);
        check("abort_in_ready", val_t'(in_ready), 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_done", val_t'(layer_done), 0);
        end

        // Recovery after reset
        send_vector(a, 0);
        drain(N_OUT, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
